// File: rtl/delay_launcher_pkg.sv
// rtl/delay_launcher_pkg.sv - shared state encoding and latency constants for delay_launcher
package delay_launcher_pkg;

  localparam int SYNC_DEF = 2;
  localparam int MIN_LAT  = SYNC_DEF + 1;

  // REARM is the absorb cycle between launches and is only reached when averaging.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRE  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    REARM = 3'd4
  } state_t;

endpackage

// File: rtl/delay_launcher_fin_catch.sv
// rtl/delay_launcher_fin_catch.sv - toggle capture of the async fin pulse plus clk synchronizer
module delay_launcher_fin_catch
  import delay_launcher_pkg::*;
#(
  parameter int SYNC = SYNC_DEF
) (
  input  logic clk,
  input  logic fin,
  output logic tsync
);

  logic            tgl;
  logic [SYNC-1:0] sync_q;

  // Sub-cycle pulses become a level change the clk domain cannot miss.
  always_ff @(posedge fin) begin
    tgl <= ~tgl;
  end

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC-2:0], tgl};
  end

  assign tsync = sync_q[SYNC-1];

endmodule

// File: rtl/delay_launcher.sv
// rtl/delay_launcher.sv - launches req into the self-timed delay and times the returning fin
// Optional launch averaging enabled by defining DELAY_LAUNCHER_AVG_EN.
module delay_launcher
  import delay_launcher_pkg::*;
#(
  parameter int CW    = 8,
  parameter int REQ_W = 2,
  parameter int TMO   = 200,
  parameter int SYNC  = SYNC_DEF
`ifdef DELAY_LAUNCHER_AVG_EN
  ,
  parameter int AVG_LOG2 = 2
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  output logic          req,
  input  logic          fin,
  output logic          done,
  output logic [CW-1:0] cycles,
  output logic          timeout
);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_inc, cap_val;
  logic          tsync, seen, fin_ev, hit, busy;
  logic          accept, launch, capture, expire, last_launch;

  delay_launcher_fin_catch #(.SYNC(SYNC)) u_fin_catch (
    .clk   (clk),
    .fin   (fin),
    .tsync (tsync)
  );

  assign fin_ev  = (tsync != seen);
  assign busy    = (state == FIRE) || (state == WAIT);
  assign cnt_inc = cnt + 1'b1;
  assign ready   = (state == IDLE);

`ifdef DELAY_LAUNCHER_AVG_EN
  localparam int ACC_W = CW + AVG_LOG2;

  logic [AVG_LOG2-1:0] lcnt;
  logic [ACC_W-1:0]    acc, acc_n;

  assign last_launch = &lcnt;
  assign acc_n       = acc + ACC_W'(cnt_inc);
  assign cap_val     = CW'(acc_n >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      lcnt <= '0;
      acc  <= '0;
    end else begin
      if (state_n == REARM) lcnt <= lcnt + 1'b1;
      if (capture)          acc  <= acc_n;
    end
  end
`else
  assign last_launch = 1'b1;
  assign cap_val     = cnt_inc;
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    launch  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FIRE;
          accept  = 1'b1;
          launch  = 1'b1;
        end
      end
      FIRE: begin
        capture = fin_ev && !hit;
        if (cnt_inc == CW'(REQ_W)) begin
          if (hit || capture) state_n = last_launch ? DONE : REARM;
          else                state_n = WAIT;
        end
      end
      WAIT: begin
        // A fin on the timeout edge still counts as a real measurement.
        if (fin_ev) begin
          capture = 1'b1;
          state_n = last_launch ? DONE : REARM;
        end else if (cnt_inc == CW'(TMO)) begin
          expire  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      REARM: begin
        state_n = FIRE;
        launch  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req     <= 1'b0;
      done    <= 1'b0;
      cycles  <= '0;
      timeout <= 1'b0;
      cnt     <= '0;
      hit     <= 1'b0;
      seen    <= tsync;
    end else begin
      state <= state_n;
      req   <= (state_n == FIRE);
      done  <= (state_n == DONE);
      if (launch) begin
        cnt <= '0;
        hit <= 1'b0;
      end else if (busy && cnt != CW'(TMO)) begin
        cnt <= cnt_inc;
      end
      if (accept) begin
        cycles  <= '0;
        timeout <= 1'b0;
      end
      if (capture) begin
        hit     <= 1'b1;
        cycles  <= cap_val;
        timeout <= 1'b0;
      end
      if (expire) begin
        cycles  <= CW'(TMO);
        timeout <= 1'b1;
      end
      // Outside a measurement every fin is swallowed so it can never be counted later.
      if (!busy || fin_ev) seen <= tsync;
    end
  end

endmodule

// File: tb/tb_delay_launcher.sv
// tb/tb_delay_launcher.sv - scoreboard bench for delay_launcher (default and DELAY_LAUNCHER_AVG_EN builds)
module tb_delay_launcher;
  import delay_launcher_pkg::*;

  localparam int CW    = 8;
  localparam int REQ_W = 2;
  localparam int TMO   = 200;
  localparam int SYNC  = 2;

  typedef struct {
    int cyc;
    int tmo;
    int lat;
    int launch;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          fin   = 1'b0;
  logic          ready, req, done, timeout;
  logic [CW-1:0] cycles;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_n      = 0;
  int   launch_edge = 0;
  int   req_run     = 0;
  logic done_d      = 1'b0;

  delay_launcher #(
    .CW    (CW),
    .REQ_W (REQ_W),
    .TMO   (TMO),
    .SYNC  (SYNC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .req     (req),
    .fin     (fin),
    .done    (done),
    .cycles  (cycles),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse and tracks req pulse width.
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", int'(done_d), 0);
      if (!done_d) begin
        check("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("cycles", int'(cycles), mon_e.cyc);
          check("timeout", int'(timeout), mon_e.tmo);
          check("done_latency", edge_n - mon_e.launch, mon_e.lat);
        end
      end
    end
    if (req) begin
      req_run++;
    end else if (req_run > 0) begin
      check("req_width", req_run, REQ_W);
      req_run = 0;
    end
    done_d = done;
  end

  task automatic launch(input int cyc, input int tmo, input int lat, input bit expect_done);
    @(negedge clk);
    start       = 1'b1;
    launch_edge = edge_n + 1;
    if (expect_done) sb.push_back('{cyc, tmo, lat, launch_edge});
    @(negedge clk);
    start = 1'b0;
    check("ready_busy", int'(ready), 0);
    check("req_launch", int'(req), 1);
  endtask

  // Pulse fin in the window (edge k, edge k+1] after the launch edge.
  task automatic fin_after(input int k);
    while (edge_n < launch_edge + k) @(negedge clk);
    fin = 1'b1;
    #1 fin = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    check(name, sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_req", int'(req), 0);
    check("rst_done", int'(done), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      fin = 1'b1;
      #1 fin = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("idle_ready", int'(ready), 1);

`ifndef DELAY_LAUNCHER_AVG_EN
    // fin in (edge 5, edge 6]; a start during FIRE must be ignored
    launch(8, 0, 8, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin_after(5);
    wait_drain("drain_k5");

    // fin during FIRE
    launch(MIN_LAT, 0, MIN_LAT, 1'b1);
    fin_after(0);
    wait_drain("drain_k0");

    // no fin: timeout, then a late fin that must be absorbed
    launch(200, 1, 200, 1'b1);
    wait_drain("drain_tmo");
    fin = 1'b1;
    #1 fin = 1'b0;
    repeat (4) @(negedge clk);

    launch(6, 0, 6, 1'b1);
    fin_after(3);
    wait_drain("drain_k3");

    // reset while in WAIT; the in-flight fin must not produce done
    launch(0, 0, 0, 1'b0);
    while (edge_n < launch_edge + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", int'(req), 0);
    check("midrst_ready", int'(ready), 1);
    check("midrst_cycles", int'(cycles), 0);
    check("midrst_done", int'(done), 0);
    fin_after(5);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    launch(8, 0, 8, 1'b1);
    fin_after(5);
    wait_drain("drain_after_rst");
`else
    // per-launch 6, 7, 7, 8 -> average 7; launches at edges 0, 7, 15, 23
    launch(7, 0, 31, 1'b1);
    fin_after(3);
    fin_after(11);
    fin_after(19);
    fin_after(28);
    wait_drain("drain_avg");
    check("avg_ready", int'(ready), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
